mu01_mem_responder: RTL
=======================

// Module: mu01_mem_responder
// PURPOSE
//  Memory-side responder for the MU01 processor's fetch/load/store bus.
//  Holds 2^AW x DW words and services single-word read/write requests over a
//  4-phase req/ack handshake, with a programmable number of wait states.
//  The processor core is the only initiator.
// PARAMETERS
//  AW           12      address width (memory depth 2^AW words)
//  DW           16      data width
//  WAIT_CYCLES  1       wait states between request capture and ack (0..15)
//  WPROT_TOP    12'h0FF highest write-protected address (MU01_MEM_WPROT_EN only)
// PORTS
//  clk     in   1   rising-edge clock
//  reset   in   1   asynchronous, active-low reset
//  req     in   1   request; held high until ack seen, then dropped
//  we      in   1   1 = write, 0 = read; stable while req high
//  addr    in   AW  word address; stable while req high
//  wdata   in   DW  write data; stable while req high
//  ack     out  1   request complete; held high until req drops
//  rdata   out  DW  read data, valid while ack high after a read
//  err     out  1   write rejected (protection); valid while ack high
//  busy    out  1   high whenever state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE, WAIT, ACK. All outputs registered.
//  - Reset (reset low, any time): state=IDLE, ack=0, err=0, busy=0,
//    rdata=0, wait counter=0. An in-flight write is dropped (memory not
//    written). Memory array is NOT cleared by reset; it powers up all-zero.
//  - IDLE: at edge N with req=1, capture we/addr/wdata. If WAIT_CYCLES=0, go
//    straight to ACK with the access performed at edge N. Otherwise load the
//    counter with WAIT_CYCLES-1 and go to WAIT.
//  - WAIT: decrement the counter each edge. At the edge where counter==0,
//    perform the access and enter ACK. Net latency: ack high after edge
//    N+WAIT_CYCLES.
//  - Access on the ACK-entry edge:
//    - Read: rdata <= mem[addr_q].
//    - Write: mem[addr_q] <= wdata_q; rdata is unchanged.
//    - err <= 0, unless set by protection.
//  - ACK: ack=1. Leave for IDLE at the first edge with req=0; ack, err and busy
//    fall at that edge. rdata holds until the next read completes. So ack is
//    high for at least 1 cycle, and a new request needs req low for at least
//    1 cycle.
//  - Inputs sampled only at capture. Changes to addr/we/wdata during WAIT or
//    ACK are ignored. req dropping in WAIT is a protocol violation: the
//    access still completes, and ack pulses for exactly 1 cycle.
//  - Full address range is valid; no wrap or out-of-range case exists.
//  - Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.
// CONFIGURATION
//  MU01_MEM_WPROT_EN defined:
//   - A write with addr_q <= WPROT_TOP is suppressed: memory is unchanged,
//     ack completes normally, err=1 while ack is high.
//   - Reads are never blocked.
//  MU01_MEM_WPROT_EN undefined:
//   - err is tied 0; all writes succeed; WPROT_TOP is unused.
// TESTING
//  1 Reset low mid-WAIT of a write (0x123 <= 0xBEEF) -> ack=0, busy=0,
//    rdata=0; a later read of 0x123 returns 0x0000.
//  2 WAIT_CYCLES=1: write 0x7FF <= 0x8001, then read 0x7FF -> each ack rises
//    2 edges after req rises (sampled at edge N, ack after N+1);
//    rdata=0x8001.
//  3 WAIT_CYCLES=0: read 0x000 after preloading 0x800F -> ack after the
//    sampling edge, rdata=0x800F; holding req for 5 cycles keeps ack high
//    for 5 cycles.
//  4 Change addr from 0x010 to 0x020 during WAIT (preloads 0x1111 and
//    0x2222) -> rdata=0x1111 (captured address used).
//  5 Boundary addresses: write 0xFFF <= 0xFFFF and 0x000 <= 0x0001, then read
//    both -> 0xFFFF and 0x0001; no aliasing.
//  6 MU01_MEM_WPROT_EN, WPROT_TOP=0x0FF: write 0x0FF <= 0xAAAA -> ack=1,
//    err=1, mem[0x0FF] unchanged. Write 0x100 <= 0xAAAA -> err=0, a read
//    returns 0xAAAA.

Source files
------------

// File: rtl/mu01_mem_responder.sv
// mu01_mem_responder: memory-side responder for the MU01 fetch/load/store bus.
// Serves single-word reads and writes over a 4-phase req/ack handshake.
// A configurable number of wait states sits between request capture and ack.
// Optional write protection of the low address region is enabled by defining
// the MU01_MEM_WPROT_EN macro.
module mu01_mem_responder #(
    parameter int            AW          = 12,
    parameter int            DW          = 16,
    parameter int            WAIT_CYCLES = 1,
    parameter logic [AW-1:0] WPROT_TOP   = AW'(12'h0FF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    // Storage has no reset; it starts out all-zero at power-up.
    logic [DW-1:0]   mem [2**AW] = '{default: '0};

    logic            acc_go;
    logic            acc_we;
    logic [AW-1:0]   acc_addr;
    logic [DW-1:0]   acc_wdata;
    logic            acc_prot;

    // Pick the access that completes on this edge: straight from the pins when
    // there are no wait states, otherwise from the captured request.
    always_comb begin
        acc_go    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_go    = req && (WAIT_CYCLES == 0);
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
        end else if (state_q == WAIT) begin
            acc_go    = (cnt_q == '0);
        end
    end

`ifdef MU01_MEM_WPROT_EN
    assign acc_prot = acc_we && (acc_addr <= WPROT_TOP);
`else
    logic unused_wprot;
    assign unused_wprot = ^WPROT_TOP;
    assign acc_prot     = 1'b0;
`endif

    // Next-state and next-output computation for the handshake FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACK;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        if (acc_go) begin
            ack_d = 1'b1;
            err_d = acc_prot;
            if (!acc_we) begin
                rdata_d = mem[acc_addr];
            end
        end
    end

    // Single register bank for the FSM and all of its outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory write port; reset forces IDLE, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (acc_go && acc_we && !acc_prot && reset) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;
    assign rdata = rdata_q;

endmodule
